// File: rtl/s3_feature_partitioner.sv
// -----------------------------------------------------------------------------
// s3_feature_partitioner
//
// Stage-3 feature-range partitioner. Given the first unprocessed feature index
// `fin`, it computes the remaining range [fin, TOTAL_F). It then streams that
// range as CHUNK-sized slices, one per cycle, to compute cores over a
// valid/ready handshake. Slice i goes to core (i mod NUM_CORES).
//
// Optional build macro: S3_STALL_CNT_EN adds a 16-bit saturating stall counter.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, fin      one-cycle request (honoured only in IDLE) and start index
//   busy            high while a request is being calculated/issued
//   last_f, f3      summary range [last_f, f3)
//   core_cnt        cores used = min(slice_cnt, NUM_CORES)
//   slice_cnt       number of slices = ceil((TOTAL_F - last_f) / CHUNK)
//   asg_valid/ready slice stream handshake
//   asg_core        target core for the presented slice
//   asg_lo, asg_hi  presented slice range [asg_lo, asg_hi)
//   done            one-cycle pulse after the last slice is issued
//   stall_cnt       (S3_STALL_CNT_EN only) cycles with asg_valid & ~asg_ready
// -----------------------------------------------------------------------------
module s3_feature_partitioner #(
  parameter int F_W        = 12,
  parameter int TOTAL_F    = 3703,
  parameter int CORE_W     = 6,
  parameter int NUM_CORES  = 64,
  parameter int CHUNK_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [F_W-1:0]    fin,
  output logic              busy,
  output logic [F_W-1:0]    last_f,
  output logic [F_W-1:0]    f3,
  output logic [CORE_W:0]   core_cnt,
  output logic [F_W-1:0]    slice_cnt,
  output logic              asg_valid,
  input  logic              asg_ready,
  output logic [CORE_W-1:0] asg_core,
  output logic [F_W-1:0]    asg_lo,
  output logic [F_W-1:0]    asg_hi,
  output logic              done
`ifdef S3_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [F_W-1:0]    TOTAL_C       = F_W'(TOTAL_F);
  localparam logic [F_W:0]      TOTAL_W_C     = (F_W+1)'(TOTAL_F);
  localparam logic [F_W:0]      CHUNK_C       = (F_W+1)'(2**CHUNK_LOG2);
  localparam logic [F_W:0]      NUM_CORES_W_C = (F_W+1)'(NUM_CORES);
  localparam logic [CORE_W:0]   NUM_CORES_C   = (CORE_W+1)'(NUM_CORES);
  localparam logic [CORE_W-1:0] LAST_CORE_C   = CORE_W'(NUM_CORES-1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_r, state_nxt_s;

  logic [F_W-1:0]    fc_r;
  logic [F_W-1:0]    idx_r;
  logic [F_W-1:0]    need_s;
  logic [F_W:0]      slices_w_s;
  logic [CORE_W:0]   cores_s;
  logic              xfer_s;
  logic              last_s;
  logic              accept_s;
  logic [F_W-1:0]    fc_nxt_s;
  logic [F_W-1:0]    idx_inc_s;
  logic [F_W-1:0]    lo_first_s;
  logic [F_W-1:0]    lo_next_s;
  logic [CORE_W-1:0] core_next_s;

  // Start of slice `idx` relative to base; always below TOTAL_F for valid idx.
  function automatic logic [F_W-1:0] slice_lo_f(input logic [F_W-1:0] base,
                                                input logic [F_W-1:0] idx);
    slice_lo_f = base + (idx << CHUNK_LOG2);
  endfunction

  // Exclusive end of a slice, clipped to the feature dimension.
  function automatic logic [F_W-1:0] slice_hi_f(input logic [F_W-1:0] lo);
    logic [F_W:0] end_w;
    end_w = {1'b0, lo} + CHUNK_C;
    if (end_w > TOTAL_W_C) begin
      slice_hi_f = TOTAL_C;
    end else begin
      slice_hi_f = end_w[F_W-1:0];
    end
  endfunction

  // Range arithmetic and handshake decode.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && start;
    fc_nxt_s    = fin;
    if (fin > TOTAL_C) begin
      fc_nxt_s = TOTAL_C;
    end else begin
      fc_nxt_s = fin;
    end
    // fc_r is clamped to TOTAL_F, so this cannot underflow.
    need_s      = TOTAL_C - fc_r;
    slices_w_s  = ({1'b0, need_s} + (CHUNK_C - (F_W+1)'(1))) >> CHUNK_LOG2;
    cores_s     = slices_w_s[CORE_W:0];
    if (slices_w_s > NUM_CORES_W_C) begin
      cores_s = NUM_CORES_C;
    end else begin
      cores_s = slices_w_s[CORE_W:0];
    end
    xfer_s      = asg_valid && asg_ready;
    last_s      = (idx_r == (slice_cnt - F_W'(1)));
    idx_inc_s   = idx_r + F_W'(1);
    lo_first_s  = slice_lo_f(fc_r, {F_W{1'b0}});
    lo_next_s   = slice_lo_f(fc_r, idx_inc_s);
    core_next_s = asg_core + CORE_W'(1);
    if (asg_core == LAST_CORE_C) begin
      core_next_s = {CORE_W{1'b0}};
    end else begin
      core_next_s = asg_core + CORE_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (need_s == {F_W{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (xfer_s && last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and status flags, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      busy      <= 1'b0;
      asg_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      busy      <= (state_nxt_s == ST_CALC) || (state_nxt_s == ST_ISSUE);
      asg_valid <= (state_nxt_s == ST_ISSUE);
      done      <= (state_nxt_s == ST_DONE);
    end
  end

  // Captured start index, summary outputs and the presented slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_r      <= {F_W{1'b0}};
      idx_r     <= {F_W{1'b0}};
      last_f    <= {F_W{1'b0}};
      f3        <= {F_W{1'b0}};
      core_cnt  <= {(CORE_W+1){1'b0}};
      slice_cnt <= {F_W{1'b0}};
      asg_core  <= {CORE_W{1'b0}};
      asg_lo    <= {F_W{1'b0}};
      asg_hi    <= {F_W{1'b0}};
    end else begin
      if (accept_s) begin
        fc_r <= fc_nxt_s;
      end
      if (state_r == ST_CALC) begin
        last_f    <= fc_r;
        f3        <= TOTAL_C;
        slice_cnt <= slices_w_s[F_W-1:0];
        core_cnt  <= cores_s;
        idx_r     <= {F_W{1'b0}};
        asg_core  <= {CORE_W{1'b0}};
        asg_lo    <= lo_first_s;
        asg_hi    <= slice_hi_f(lo_first_s);
      end else if ((state_r == ST_ISSUE) && xfer_s && !last_s) begin
        // Advance only on a transfer so a stalled slice stays stable.
        idx_r    <= idx_inc_s;
        asg_core <= core_next_s;
        asg_lo   <= lo_next_s;
        asg_hi   <= slice_hi_f(lo_next_s);
      end
    end
  end

`ifdef S3_STALL_CNT_EN
  // Saturating count of stalled slice cycles, cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (accept_s) begin
      stall_cnt <= 16'h0000;
    end else if (asg_valid && !asg_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_s3_feature_partitioner.sv
module tb_s3_feature_partitioner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] fin = 12'd0;
  logic        busy;
  logic [11:0] last_f;
  logic [11:0] f3;
  logic [6:0]  core_cnt;
  logic [11:0] slice_cnt;
  logic        asg_valid;
  logic        asg_ready = 1'b1;
  logic [5:0]  asg_core;
  logic [11:0] asg_lo;
  logic [11:0] asg_hi;
  logic        done;
`ifdef S3_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Transfers observed by the collector.
  int lo_a[256];
  int hi_a[256];
  int core_a[256];
  int n_xfer;
  int done_cyc;
  int first_valid_cyc;
  int last_xfer_cyc;
  bit timeout;

  s3_feature_partitioner dut (
    .clk(clk), .rst(rst), .start(start), .fin(fin), .busy(busy),
    .last_f(last_f), .f3(f3), .core_cnt(core_cnt), .slice_cnt(slice_cnt),
    .asg_valid(asg_valid), .asg_ready(asg_ready), .asg_core(asg_core),
    .asg_lo(asg_lo), .asg_hi(asg_hi), .done(done)
`ifdef S3_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle start; returns one cycle after it was sampled (cycle 1).
  task automatic start_run(input logic [11:0] f);
    start = 1'b1;
    fin = f;
    step();
    start = 1'b0;
  endtask

  // Record transfers until done or the budget expires. Entered at cycle 1.
  task automatic collect(input int repulse_at, input int budget);
    int cyc;
    n_xfer = 0; done_cyc = -1; first_valid_cyc = -1; last_xfer_cyc = -1;
    timeout = 1'b1;
    cyc = 1;
    while (cyc <= budget) begin
      if (asg_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (asg_valid && asg_ready && n_xfer < 256) begin
        lo_a[n_xfer] = asg_lo; hi_a[n_xfer] = asg_hi; core_a[n_xfer] = asg_core;
        n_xfer++;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        timeout = 1'b0;
        break;
      end
      if (cyc == repulse_at) begin
        start = 1'b1;
        fin = 12'd3000;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    tests_run++;
    if ({busy, asg_valid, done, last_f, f3, core_cnt, slice_cnt, asg_core, asg_lo, asg_hi} !== 79'd0) begin
      tests_failed++; $display("FAIL reset_outputs got busy=%0d valid=%0d done=%0d last_f=%0d lo=%0d exp all 0", busy, asg_valid, done, last_f, asg_lo);
    end
`ifdef S3_STALL_CNT_EN
    tests_run++;
    if (stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
`endif
    rst = 1'b0;
    step();
    tests_run++;
    if ({busy, asg_valid, done} !== 3'b000) begin
      tests_failed++; $display("FAIL idle_after_reset got=%b exp=000", {busy, asg_valid, done});
    end
  endtask

  task automatic test_basic();
    int bad;
    asg_ready = 1'b1;
    start_run(12'd3000);
    tests_run++;
    if ({busy, asg_valid} !== 2'b10) begin tests_failed++; $display("FAIL basic_calc got=%b exp=10", {busy, asg_valid}); end
    collect(0, 100);
    tests_run++;
    if (timeout !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout got=%0d exp=0", timeout); end
    tests_run++;
    if (n_xfer !== 22) begin tests_failed++; $display("FAIL basic_nxfer got=%0d exp=22", n_xfer); end
    tests_run++;
    if (first_valid_cyc !== 2) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=2", first_valid_cyc); end
    tests_run++;
    if (lo_a[0] !== 3000 || hi_a[0] !== 3032 || core_a[0] !== 0) begin
      tests_failed++; $display("FAIL basic_first got=[%0d,%0d) c%0d exp=[3000,3032) c0", lo_a[0], hi_a[0], core_a[0]);
    end
    tests_run++;
    if (lo_a[21] !== 3672 || hi_a[21] !== 3703 || core_a[21] !== 21) begin
      tests_failed++; $display("FAIL basic_last got=[%0d,%0d) c%0d exp=[3672,3703) c21", lo_a[21], hi_a[21], core_a[21]);
    end
    bad = 0;
    for (int i = 0; i < 21; i++) begin
      if (lo_a[i] !== 3000 + 32 * i || hi_a[i] !== 3032 + 32 * i || core_a[i] !== i) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL basic_sequence got=%0d bad slices exp=0", bad); end
    tests_run++;
    if (slice_cnt !== 12'd22 || core_cnt !== 7'd22 || last_f !== 12'd3000 || f3 !== 12'd3703) begin
      tests_failed++; $display("FAIL basic_summary got=s%0d c%0d lf%0d f3=%0d exp=s22 c22 lf3000 f3=3703", slice_cnt, core_cnt, last_f, f3);
    end
    tests_run++;
    if (done_cyc !== 24 || last_xfer_cyc !== 23) begin
      tests_failed++; $display("FAIL basic_done_timing got=done%0d xfer%0d exp=done24 xfer23", done_cyc, last_xfer_cyc);
    end
    tests_run++;
    if ({busy, asg_valid} !== 2'b00) begin tests_failed++; $display("FAIL basic_done_state got=%b exp=00", {busy, asg_valid}); end
    step();
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got=%0d exp=0", done); end
  endtask

  task automatic test_wrap();
    start_run(12'd1000);
    collect(0, 200);
    tests_run++;
    if (timeout !== 1'b0 || n_xfer !== 85) begin tests_failed++; $display("FAIL wrap_nxfer got=%0d to=%0d exp=85", n_xfer, timeout); end
    tests_run++;
    if (slice_cnt !== 12'd85 || core_cnt !== 7'd64) begin
      tests_failed++; $display("FAIL wrap_summary got=s%0d c%0d exp=s85 c64", slice_cnt, core_cnt);
    end
    tests_run++;
    if (core_a[63] !== 63 || lo_a[63] !== 3016) begin
      tests_failed++; $display("FAIL wrap_s63 got=%0d c%0d exp=3016 c63", lo_a[63], core_a[63]);
    end
    tests_run++;
    if (lo_a[64] !== 3048 || hi_a[64] !== 3080 || core_a[64] !== 0) begin
      tests_failed++; $display("FAIL wrap_s64 got=[%0d,%0d) c%0d exp=[3048,3080) c0", lo_a[64], hi_a[64], core_a[64]);
    end
    tests_run++;
    if (lo_a[84] !== 3688 || hi_a[84] !== 3703 || core_a[84] !== 20) begin
      tests_failed++; $display("FAIL wrap_s84 got=[%0d,%0d) c%0d exp=[3688,3703) c20", lo_a[84], hi_a[84], core_a[84]);
    end
    step();
  endtask

  task automatic test_empty();
    logic [11:0] fins[2];
    fins[0] = 12'd3703;
    fins[1] = 12'd4000;
    for (int k = 0; k < 2; k++) begin
      start_run(fins[k]);
      collect(0, 20);
      tests_run++;
      if (last_f !== 12'd3703 || slice_cnt !== 12'd0 || core_cnt !== 7'd0 || f3 !== 12'd3703) begin
        tests_failed++; $display("FAIL empty_summary fin=%0d got=lf%0d s%0d c%0d exp=lf3703 s0 c0", fins[k], last_f, slice_cnt, core_cnt);
      end
      tests_run++;
      if (n_xfer !== 0 || first_valid_cyc !== -1) begin
        tests_failed++; $display("FAIL empty_novalid fin=%0d got=x%0d v%0d exp=x0 v-1", fins[k], n_xfer, first_valid_cyc);
      end
      tests_run++;
      if (done_cyc !== 2) begin tests_failed++; $display("FAIL empty_done fin=%0d got=%0d exp=2", fins[k], done_cyc); end
      step();
    end
  endtask

  task automatic test_stall();
    asg_ready = 1'b0;
    start_run(12'd3690);
    step();
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (asg_valid !== 1'b1 || asg_lo !== 12'd3690 || asg_hi !== 12'd3703 || asg_core !== 6'd0) begin
        tests_failed++; $display("FAIL stall_hold k=%0d got=v%0d [%0d,%0d) c%0d exp=v1 [3690,3703) c0", k, asg_valid, asg_lo, asg_hi, asg_core);
      end
      step();
    end
    asg_ready = 1'b1;
    tests_run++;
    if (asg_valid !== 1'b1 || asg_lo !== 12'd3690 || slice_cnt !== 12'd1 || core_cnt !== 7'd1) begin
      tests_failed++; $display("FAIL stall_release got=v%0d lo%0d s%0d c%0d exp=v1 lo3690 s1 c1", asg_valid, asg_lo, slice_cnt, core_cnt);
    end
    step();
    tests_run++;
    if (done !== 1'b1 || asg_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stall_done got=d%0d v%0d exp=d1 v0", done, asg_valid);
    end
    step();
`ifdef S3_STALL_CNT_EN
    tests_run++;
    if (stall_cnt !== 16'd5) begin tests_failed++; $display("FAIL stall_cnt got=%0d exp=5", stall_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    start_run(12'd0);
    collect(5, 300);
    tests_run++;
    if (timeout !== 1'b0 || n_xfer !== 116) begin tests_failed++; $display("FAIL b2b_nxfer got=%0d to=%0d exp=116", n_xfer, timeout); end
    tests_run++;
    if (lo_a[0] !== 0 || lo_a[115] !== 3680 || hi_a[115] !== 3703 || core_a[115] !== 51) begin
      tests_failed++; $display("FAIL b2b_slices got=first%0d last=[%0d,%0d) c%0d exp=first0 [3680,3703) c51", lo_a[0], lo_a[115], hi_a[115], core_a[115]);
    end
    tests_run++;
    if (last_f !== 12'd0 || slice_cnt !== 12'd116 || core_cnt !== 7'd64 || done_cyc !== 118) begin
      tests_failed++; $display("FAIL b2b_summary got=lf%0d s%0d c%0d d%0d exp=lf0 s116 c64 d118", last_f, slice_cnt, core_cnt, done_cyc);
    end
    step();
  endtask

  task automatic test_reset_mid_issue();
    int guard;
    bit found;
    asg_ready = 1'b1;
    start_run(12'd0);
    found = 1'b0;
    guard = 0;
    while (guard < 40 && !found) begin
      if (asg_valid && asg_lo == 12'd320) found = 1'b1;
      else begin step(); guard++; end
    end
    tests_run++;
    if (found !== 1'b1) begin tests_failed++; $display("FAIL midrst_reach got=%0d exp=1", found); end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, asg_valid, done, last_f, f3, core_cnt, slice_cnt, asg_core, asg_lo, asg_hi} !== 79'd0) begin
      tests_failed++; $display("FAIL midrst_async got busy=%0d valid=%0d lo=%0d core=%0d exp all 0", busy, asg_valid, asg_lo, asg_core);
    end
    step();
    rst = 1'b0;
    step(); step();
    tests_run++;
    if ({busy, asg_valid, done} !== 3'b000) begin
      tests_failed++; $display("FAIL midrst_quiet got=%b exp=000", {busy, asg_valid, done});
    end
    start_run(12'd3000);
    collect(0, 100);
    tests_run++;
    if (timeout !== 1'b0 || n_xfer !== 22 || lo_a[0] !== 3000 || core_a[0] !== 0) begin
      tests_failed++; $display("FAIL midrst_restart got=x%0d lo%0d c%0d to%0d exp=x22 lo3000 c0 to0", n_xfer, lo_a[0], core_a[0], timeout);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_empty();
    test_stall();
    test_back_to_back();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/s3_feature_partitioner.md
Name: s3_feature_partitioner

Overview:
- Sequential, parametrised successor to the stage-3 feature-range calculator.
- Takes the first unprocessed feature index `fin` from stage 1 or stage 2. Computes the remaining feature range [fin, TOTAL_F).
- Splits that range into CHUNK-sized slices and issues one slice per cycle to compute cores over a valid/ready stream. Slice index maps to core round-robin.
- Sits between the stage-select state machine and the core dispatch logic. Reports summary range, core count and completion.

Parameters:
- F_W, 12, width of feature indices and counts
- TOTAL_F, 3703, total feature dimension (Citeseer)
- CORE_W, 6, width of core id
- NUM_CORES, 64, number of physical cores (<= 2**CORE_W)
- CHUNK_LOG2, 5, log2 of features per slice (CHUNK = 32)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- fin  in  F_W  first unprocessed feature index
- busy  out  1  high from the cycle after an accepted start until done
- last_f  out  F_W  registered copy of fin (clamped to TOTAL_F)
- f3  out  F_W  exclusive end of range, always TOTAL_F once valid
- core_cnt  out  CORE_W+1  cores used = min(slices, NUM_CORES)
- slice_cnt  out  F_W  total slices = ceil(need/CHUNK)
- asg_valid  out  1  slice assignment valid
- asg_ready  in  1  dispatch accepts slice
- asg_core  out  CORE_W  target core = slice_idx mod NUM_CORES
- asg_lo  out  F_W  slice start feature (inclusive)
- asg_hi  out  F_W  slice end feature (exclusive)
- done  out  1  one-cycle pulse when all slices are issued

Behaviour:
- Reset (async, any state): state=IDLE. Outputs busy, asg_valid and done are 0. Outputs last_f, f3, core_cnt, slice_cnt, asg_core, asg_lo and asg_hi are 0. The slice index is 0.
- FSM states: IDLE, CALC, ISSUE, DONE.
- IDLE: start=1 moves to CALC.
  - Register fc = min(fin, TOTAL_F).
  - busy rises next cycle.
  - start in any other state is ignored.
- CALC (1 cycle):
  - need = TOTAL_F - fc, computed F_W bits with no underflow thanks to the clamp.
  - slice_cnt = (need + CHUNK-1) >> CHUNK_LOG2, computed at F_W+1 bits.
  - core_cnt = min(slice_cnt, NUM_CORES).
  - last_f = fc; f3 = TOTAL_F.
  - If need == 0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - asg_valid = 1.
  - asg_lo = fc + (idx << CHUNK_LOG2).
  - asg_hi = min(asg_lo + CHUNK, TOTAL_F).
  - asg_core = idx mod NUM_CORES (wraps 63 -> 0).
  - Handshake:
    - Transfer when asg_valid & asg_ready.
    - While stalled, asg_core, asg_lo and asg_hi are held stable and asg_valid stays high.
    - On a transfer of the last slice (idx == slice_cnt-1), go to DONE and drop asg_valid the next cycle.
    - Otherwise idx increments and the next slice is presented the next cycle. Throughput is 1 slice/cycle.
- DONE (1 cycle): done=1, busy=0, then IDLE. Summary outputs hold until the next CALC.
- Latency: first asg_valid appears 2 cycles after start is sampled.
- Reset mid-ISSUE aborts immediately. No slice is reported after reset deassertion until a new start.

Optional Feature:
- Macro: S3_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], which counts cycles with asg_valid & ~asg_ready.
  - It saturates at 16'hFFFF, clears on accepted start and on reset, and holds after done.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- fin=3000, asg_ready=1 -> 22 slices: first [3000,3032) core 0, last [3672,3703) core 21. Also core_cnt=22, slice_cnt=22, done 1 cycle after the last transfer.
- fin=1000, asg_ready=1 -> slice_cnt=85, core_cnt=64. Slice 64 is [3048,3080) on core 0; slice 84 is [3688,3703) on core 20.
- fin=3703, and separately fin=4000 -> last_f=3703, slice_cnt=0, core_cnt=0. No asg_valid; done pulses 2 cycles after start.
- fin=3690 with asg_ready held low 5 cycles -> single slice [3690,3703) core 0 held stable across the stall. Transfer on the 6th cycle. With S3_STALL_CNT_EN, stall_cnt=5.
- fin=0 with start re-pulsed during ISSUE -> second start ignored; 116 slices issued, the last being [3680,3703).
- Reset asserted during ISSUE at slice 10 -> busy=0, asg_valid=0, all outputs 0 asynchronously. A new start with fin=3000 restarts from slice 0.
